// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, FSM encoding, instruction fields.
package alu_ctrl_pkg;

   localparam int ALU_DATA_W = 16;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_XNOR = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_DIV  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_READ = 2'b01,
      ST_EXEC = 2'b10,
      ST_WB   = 2'b11
   } state_e;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 13;
   localparam int RD_MSB  = 12;
   localparam int RD_LSB  = 10;
   localparam int RS1_MSB = 9;
   localparam int RS1_LSB = 7;
   localparam int RS2_MSB = 6;
   localparam int RS2_LSB = 4;

   typedef struct packed {
      logic [2:0] op;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
   } instr_t;

   function automatic instr_t decode_instr(input logic [15:4] raw);
      instr_t d;
      d.op  = raw[OP_MSB:OP_LSB];
      d.rd  = raw[RD_MSB:RD_LSB];
      d.rs1 = raw[RS1_MSB:RS1_LSB];
      d.rs2 = raw[RS2_MSB:RS2_LSB];
      return d;
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8-entry register file: two capture-on-enable operand ports, a combinational debug port,
// and one write port shared between host writes and write-back.
module alu_regfile
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              host_we,
   input  logic [2:0]        host_waddr,
   input  logic [DATA_W-1:0] host_wdata,
   input  logic              wb_we,
   input  logic [2:0]        wb_waddr,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic              rd_en,
   input  logic [2:0]        rs1,
   input  logic [2:0]        rs2,
   output logic [DATA_W-1:0] rd1_data,
   output logic [DATA_W-1:0] rd2_data,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] mem_r [8];
   logic [DATA_W-1:0] rd1_r;
   logic [DATA_W-1:0] rd2_r;
   logic              we_s;
   logic [2:0]        waddr_s;
   logic [DATA_W-1:0] wdata_s;

   // Write mux; host and write-back strobes are never active together (IDLE vs WB)
   always_comb begin
      we_s    = 1'b0;
      waddr_s = 3'd0;
      wdata_s = {DATA_W{1'b0}};
      if (host_we) begin
         we_s    = 1'b1;
         waddr_s = host_waddr;
         wdata_s = host_wdata;
      end else if (wb_we) begin
         we_s    = 1'b1;
         waddr_s = wb_waddr;
         wdata_s = wb_wdata;
      end else begin
         we_s    = 1'b0;
      end
   end

   // Register storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
      end else if (we_s) begin
         mem_r[waddr_s] <= wdata_s;
      end
   end

   // Operand capture; values hold while rd_en is low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd1_r <= {DATA_W{1'b0}};
         rd2_r <= {DATA_W{1'b0}};
      end else if (rd_en) begin
         rd1_r <= mem_r[rs1];
         rd2_r <= mem_r[rs2];
      end
   end

   assign rd1_data = rd1_r;
   assign rd2_data = rd2_r;
   assign dbg_data = mem_r[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back sequencer in front of the external 16-bit ALU (IDLE->READ->EXEC->WB).
// Optional divide-by-zero trap enabled by defining DIV_ZERO_TRAP_EN.
module alu_issue_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W  = ALU_DATA_W,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instr,
   input  logic               host_wr_en,
   input  logic [2:0]         host_wr_addr,
   input  logic [DATA_W-1:0]  host_wr_data,
   input  logic [2:0]         dbg_rd_addr,
   output logic [DATA_W-1:0]  dbg_rd_data,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   output logic [2:0]         alu_op,
   input  logic [DATA_W-1:0]  alu_out,
   output logic               done,
   output logic [DATA_W-1:0]  result,
   output logic               err
);

   state_e            state_r;
   state_e            state_s;
   instr_t            instr_r;
   logic [2:0]        alu_op_r;
   logic [DATA_W-1:0] result_r;
   logic              trap_r;
   logic              trap_s;
   logic              instr_ready_s;
   logic              read_en_s;
   logic              exec_s;
   logic              done_s;
   logic              err_s;
   logic              accept_s;
   logic              host_we_s;
   logic              wb_we_s;
   logic [DATA_W-1:0] rd1_s;
   logic [DATA_W-1:0] rd2_s;
   logic              unused_s;

   assign unused_s  = ^instr[3:0];
   assign accept_s  = instr_ready_s & instr_valid;
   assign host_we_s = instr_ready_s & host_wr_en;
   assign wb_we_s   = done_s & ~trap_r;

`ifdef DIV_ZERO_TRAP_EN
   assign trap_s = (alu_op_r == OP_DIV) && (rd2_s == {DATA_W{1'b0}});
`else
   assign trap_s = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (instr_valid) begin
               state_s = ST_READ;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_READ: state_s = ST_EXEC;
         ST_EXEC: state_s = ST_WB;
         ST_WB:   state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Output and strobe decode
   always_comb begin
      instr_ready_s = 1'b0;
      read_en_s     = 1'b0;
      exec_s        = 1'b0;
      done_s        = 1'b0;
      err_s         = 1'b0;
      case (state_r)
         ST_IDLE: instr_ready_s = 1'b1;
         ST_READ: read_en_s     = 1'b1;
         ST_EXEC: exec_s        = 1'b1;
         ST_WB: begin
            done_s = 1'b1;
            err_s  = trap_r;
         end
         default: instr_ready_s = 1'b0;
      endcase
   end

   // Instruction latch, opcode issue, result and trap capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_r  <= '{3'd0, 3'd0, 3'd0, 3'd0};
         alu_op_r <= 3'b000;
         result_r <= {DATA_W{1'b0}};
         trap_r   <= 1'b0;
      end else begin
         if (accept_s) begin
            instr_r <= decode_instr(instr[15:4]);
         end
         if (read_en_s) begin
            alu_op_r <= instr_r.op;
         end
         if (exec_s) begin
            result_r <= alu_out;
            trap_r   <= trap_s;
         end
      end
   end

   alu_regfile #(.DATA_W(DATA_W)) u_rf (
      .clk        (clk),
      .rst        (rst),
      .host_we    (host_we_s),
      .host_waddr (host_wr_addr),
      .host_wdata (host_wr_data),
      .wb_we      (wb_we_s),
      .wb_waddr   (instr_r.rd),
      .wb_wdata   (result_r),
      .rd_en      (read_en_s),
      .rs1        (instr_r.rs1),
      .rs2        (instr_r.rs2),
      .rd1_data   (rd1_s),
      .rd2_data   (rd2_s),
      .dbg_addr   (dbg_rd_addr),
      .dbg_data   (dbg_rd_data)
   );

   assign instr_ready = instr_ready_s;
   assign alu_a       = rd1_s;
   assign alu_b       = rd2_s;
   assign alu_op      = alu_op_r;
   assign result      = result_r;
   assign done        = done_s;
   assign err         = err_s;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and register-file model.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic        host_wr_en;
   logic [2:0]  host_wr_addr;
   logic [15:0] host_wr_data;
   logic [2:0]  dbg_rd_addr;
   logic [15:0] dbg_rd_data;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [2:0]  alu_op;
   logic [15:0] alu_out;
   logic        done;
   logic [15:0] result;
   logic        err;

   int          ncmp = 0;
   int          nfail = 0;
   logic [15:0] ref_rf [8];
   logic [15:0] exp_res;

   always #5 clk = ~clk;

   // Stand-in for the team ALU; divide by zero returns all ones
   function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a ^ b);
         3'd4:    return a + b;
         3'd5:    return a - b;
         3'd6:    return a * b;
         default: return (b == 16'd0) ? 16'hFFFF : a / b;
      endcase
   endfunction

   assign alu_out = alu_f(alu_op, alu_a, alu_b);

   alu_issue_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .host_wr_en   (host_wr_en),
      .host_wr_addr (host_wr_addr),
      .host_wr_data (host_wr_data),
      .dbg_rd_addr  (dbg_rd_addr),
      .dbg_rd_data  (dbg_rd_data),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_out      (alu_out),
      .done         (done),
      .result       (result),
      .err          (err)
   );

   function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
      return {op, rd, rs1, rs2, 4'h0};
   endfunction

   function automatic logic trap_f(input logic [2:0] op, input logic [15:0] b);
`ifdef DIV_ZERO_TRAP_EN
      return (op == 3'd7) && (b == 16'd0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reg(input string tag, input logic [2:0] addr);
      dbg_rd_addr = addr;
      #1;
      check(tag, {16'd0, dbg_rd_data}, {16'd0, ref_rf[addr]});
   endtask

   // Called at a negedge while idle; returns at a negedge
   task automatic host_write(input logic [2:0] addr, input logic [15:0] data);
      host_wr_en   = 1'b1;
      host_wr_addr = addr;
      host_wr_data = data;
      @(posedge clk);
      ref_rf[addr] = data;
      @(negedge clk);
      host_wr_en = 1'b0;
   endtask

   // Issue one instruction; optional same-edge host write and a host write during a busy cycle
   task automatic issue(input logic [15:0] ins, input logic pre_en, input logic [2:0] pre_addr,
                        input logic [15:0] pre_data, input int hw_cycle,
                        input logic [2:0] hw_addr, input logic [15:0] hw_data);
      logic [2:0]  op;
      logic [2:0]  rd;
      logic [15:0] a;
      logic [15:0] b;
      logic        trap;
      int          lat;
      op = ins[15:13];
      rd = ins[12:10];
      check("ready_before_accept", {31'd0, instr_ready}, 32'd1);
      instr_valid  = 1'b1;
      instr        = ins;
      host_wr_en   = pre_en;
      host_wr_addr = pre_addr;
      host_wr_data = pre_data;
      @(posedge clk);
      if (pre_en) ref_rf[pre_addr] = pre_data;
      a       = ref_rf[ins[9:7]];
      b       = ref_rf[ins[6:4]];
      exp_res = alu_f(op, a, b);
      trap    = trap_f(op, b);
      @(negedge clk);
      instr_valid = 1'b0;
      host_wr_en  = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 12) begin
         host_wr_en   = (lat == hw_cycle);
         host_wr_addr = hw_addr;
         host_wr_data = hw_data;
         @(negedge clk);
         lat++;
      end
      host_wr_en = 1'b0;
      check("done_latency", lat, 32'd3);
      check("result", {16'd0, result}, {16'd0, exp_res});
      check("err", {31'd0, err}, {31'd0, trap});
      check("alu_a_held", {16'd0, alu_a}, {16'd0, a});
      check("alu_b_held", {16'd0, alu_b}, {16'd0, b});
      check("alu_op_held", {29'd0, alu_op}, {29'd0, op});
      if (!trap) ref_rf[rd] = exp_res;
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("err_outside_wb", {31'd0, err}, 32'd0);
      check("ready_after_wb", {31'd0, instr_ready}, 32'd1);
      check_reg("rd_writeback", rd);
      if (hw_cycle > 0) check_reg("busy_host_write_ignored", hw_addr);
   endtask

   initial begin
      logic [15:0] q [3];
      int          acc [3];
      int          idx;
      logic [15:0] rv;

      rst          = 1'b1;
      instr_valid  = 1'b0;
      instr        = 16'h0000;
      host_wr_en   = 1'b0;
      host_wr_addr = 3'd0;
      host_wr_data = 16'h0000;
      dbg_rd_addr  = 3'd0;
      for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0000;
      #12;
      check("rst_ready", {31'd0, instr_ready}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_result", {16'd0, result}, 32'd0);
      check("rst_alu_a", {16'd0, alu_a}, 32'd0);
      check("rst_alu_b", {16'd0, alu_b}, 32'd0);
      check("rst_alu_op", {29'd0, alu_op}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) check_reg("rst_regs", 3'(i));

      // Directed arithmetic cases
      host_write(3'd1, 16'h0005);
      host_write(3'd2, 16'h0003);
      issue(16'h8CA0, 1'b0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      check("add_const", {16'd0, result}, 32'h0008);
      issue(16'hB110, 1'b0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      check("sub_wrap_const", {16'd0, result}, 32'hFFFE);
      host_write(3'd5, 16'h0100);
      issue(16'hDAD0, 1'b0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      check("mul_trunc_const", {16'd0, result}, 32'h0000);
      host_write(3'd1, 16'h00FF);
      host_write(3'd2, 16'h0F0F);
      issue(mk(3'd0, 3'd3, 3'd1, 3'd2), 1'b0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      check("and_const", {16'd0, result}, 32'h000F);
      issue(mk(3'd1, 3'd4, 3'd1, 3'd2), 1'b0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      check("or_const", {16'd0, result}, 32'h0FFF);
      issue(mk(3'd2, 3'd5, 3'd1, 3'd2), 1'b0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      check("xor_const", {16'd0, result}, 32'h0FF0);
      issue(mk(3'd3, 3'd6, 3'd1, 3'd2), 1'b0, 3'd0, 16'h0, 0, 3'd0, 16'h0);
      check("xnor_const", {16'd0, result}, 32'hF00F);

      // Divide by zero into a register with a known prior value
      host_write(3'd7, 16'h1234);
      issue(mk(3'd7, 3'd7, 3'd1, 3'd0), 1'b0, 3'd0, 16'h0, 0, 3'd0, 16'h0);

      // Host write on the accept edge is seen by READ; rd==rs1 self-update
      issue(mk(3'd4, 3'd2, 3'd2, 3'd1), 1'b1, 3'd2, 16'h0007, 0, 3'd0, 16'h0);
      check("same_edge_write_const", {16'd0, result}, 32'h0106);

      // Host writes during READ and EXEC are ignored
      issue(mk(3'd4, 3'd3, 3'd1, 3'd2), 1'b0, 3'd0, 16'h0, 2, 3'd5, 16'hDEAD);
      issue(mk(3'd5, 3'd4, 3'd1, 3'd2), 1'b0, 3'd0, 16'h0, 1, 3'd6, 16'hBEEF);

      // instr_valid held high across three instructions
      q[0] = mk(3'd4, 3'd3, 3'd1, 3'd2);
      q[1] = mk(3'd6, 3'd4, 3'd3, 3'd1);
      q[2] = mk(3'd2, 3'd5, 3'd4, 3'd3);
      idx = 0;
      for (int n = 0; n < 20; n++) begin
         if (instr_ready === 1'b1) begin
            if (idx < 3) begin
               acc[idx]    = n;
               instr_valid = 1'b1;
               instr       = q[idx];
               ref_rf[q[idx][12:10]] = alu_f(q[idx][15:13], ref_rf[q[idx][9:7]], ref_rf[q[idx][6:4]]);
               idx++;
            end else begin
               instr_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      instr_valid = 1'b0;
      check("held_accept_count", idx, 32'd3);
      check("held_gap_1", acc[1] - acc[0], 32'd4);
      check("held_gap_2", acc[2] - acc[1], 32'd4);
      for (int i = 3; i < 6; i++) check_reg("held_results", 3'(i));

      // Reset during EXEC drops the instruction
      instr_valid = 1'b1;
      instr       = mk(3'd4, 3'd6, 3'd1, 3'd2);
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_result", {16'd0, result}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0000;
      @(negedge clk);
      check("midrst_ready_after", {31'd0, instr_ready}, 32'd1);
      for (int n = 0; n < 4; n++) begin
         check("midrst_no_done", {31'd0, done}, 32'd0);
         @(negedge clk);
      end
      for (int i = 0; i < 8; i++) check_reg("midrst_regs", 3'(i));

      // Randomized instructions against the model
      for (int n = 0; n < 40; n++) begin
         rv = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         host_write(3'($urandom_range(0, 7)), rv);
         issue(mk(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7))),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
               $urandom_range(0, 2), 3'($urandom_range(0, 7)), 16'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
